// File: rtl/cnn_loader_pkg.sv
// Shared types, address defaults and the pixel-address helper for the layer1 pixel loader.
// Optional checksum feature in the loader is controlled by CNN_LOADER_CKSUM_EN.
package cnn_loader_pkg;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      DONE
   } loader_state_t;

   localparam logic [15:0] DEF_PIX_BASE  = 16'hc000;
   localparam logic [31:0] DEF_CTRL_ADDR = 32'hc001_0000;

   // Same {row,col} layout layer1 uses when it reads the pixel store.
   function automatic logic [15:0] pix_addr(input logic [10:0] row, input logic [4:0] col);
      return {row, col};
   endfunction

endpackage

// File: rtl/cnn_pixel_loader_if.sv
// Bus write-beat bundle feeding the pixel loader (address/data with separate valids, no ready).
interface cnn_pixel_loader_if;

   logic [31:0] awaddr;
   logic        awvalid;
   logic [31:0] wdata;
   logic        wvalid;

   modport master (output awaddr, awvalid, wdata, wvalid);
   modport slave  (input  awaddr, awvalid, wdata, wvalid);

endinterface

// File: rtl/pixel_pack_shift.sv
// Three 16-bit channel registers filled slot by slot; word_o already includes the sample
// being loaded this cycle so the packed pixel can be registered on the third beat.
module pixel_pack_shift
   import cnn_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic [1:0]  slot_i,
   input  logic [15:0] sample_i,
   output logic [47:0] word_o
);

   logic [2:0][15:0] ch_q;
   logic [2:0][15:0] ch_d;

   always_comb begin
      // NOTE: default assignment first so no path leaves ch_d unassigned (no latch).
      ch_d = ch_q;
      if (load_i && (slot_i != 2'd3)) begin
         ch_d[slot_i] = sample_i;
      end
   end

   // NOTE: only three words, so resetting them is cheap and keeps simulation X-free;
   // a real RAM-sized store would be left unreset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ch_q <= '0;
      end else begin
         ch_q <= ch_d;
      end
   end

   assign word_o = ch_d;

endmodule

// File: rtl/cnn_pixel_loader.sv
// Packs three channel beats per pixel and writes them to the layer1 pixel store; raises
// pixel_store_done once the image is complete. Define CNN_LOADER_CKSUM_EN for the checksum port.
module cnn_pixel_loader
   import cnn_loader_pkg::*;
#(
   parameter int unsigned IMG_W     = 32,
   parameter int unsigned IMG_H     = 32,
   parameter logic [15:0] PIX_BASE  = DEF_PIX_BASE,
   parameter logic [31:0] CTRL_ADDR = DEF_CTRL_ADDR
) (
   input  logic                     clk,
   input  logic                     rst,
   cnn_pixel_loader_if.slave        bus,
   output logic                     write_pixel_signal,
   output logic [15:0]              write_pixel_addr,
   output logic [47:0]              write_pixel_data,
   output logic                     pixel_store_done,
   output logic                     loader_busy,
   output logic                     overflow
`ifdef CNN_LOADER_CKSUM_EN
   ,
   output logic [15:0]              checksum
`endif
);

   localparam logic [4:0]  COL_LAST = 5'(IMG_W - 1);
   localparam logic [10:0] ROW_LAST = 11'(IMG_H - 1);

   loader_state_t state_q;
   logic [1:0]    ch_cnt_q;
   logic [4:0]    col_q;
   logic [10:0]   row_q;
   logic          strobe_q;
   logic [15:0]   addr_q;
   logic [47:0]   data_q;
   logic          done_q;
   logic          ovf_q;
`ifdef CNN_LOADER_CKSUM_EN
   logic [15:0]   cksum_q;
`endif

   logic          accept;
   logic          pix_beat;
   logic          restart;
   logic          load;
   logic [47:0]   word;
   logic          unused_wdata_hi;

   assign accept          = bus.awvalid && bus.wvalid;
   assign pix_beat        = accept && (bus.awaddr[31:16] == PIX_BASE);
   assign restart         = accept && (bus.awaddr == CTRL_ADDR) && bus.wdata[0];
   assign load            = pix_beat && (state_q != DONE);
   assign unused_wdata_hi = ^bus.wdata[31:16];

   pixel_pack_shift u_pack (
      .clk      (clk),
      .rst      (rst),
      .load_i   (load),
      .slot_i   (ch_cnt_q),
      .sample_i (bus.wdata[15:0]),
      .word_o   (word)
   );

   // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         ch_cnt_q <= '0;
         col_q    <= '0;
         row_q    <= '0;
         strobe_q <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
`ifdef CNN_LOADER_CKSUM_EN
         cksum_q  <= '0;
`endif
      end else if (restart) begin
         state_q  <= IDLE;
         ch_cnt_q <= '0;
         col_q    <= '0;
         row_q    <= '0;
         strobe_q <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
`ifdef CNN_LOADER_CKSUM_EN
         cksum_q  <= '0;
`endif
      end else begin
         strobe_q <= 1'b0;
         // Done lags the final strobe by one cycle; DONE is left only via restart or reset.
         done_q   <= (state_q == DONE);
`ifdef CNN_LOADER_CKSUM_EN
         if (load) cksum_q <= cksum_q + bus.wdata[15:0];
`endif
         case (state_q)
            IDLE: begin
               if (pix_beat) begin
                  state_q  <= COLLECT;
                  ch_cnt_q <= 2'd1;
               end
            end
            COLLECT: begin
               if (pix_beat) begin
                  if (ch_cnt_q == 2'd2) begin
                     ch_cnt_q <= '0;
                     strobe_q <= 1'b1;
                     addr_q   <= pix_addr(row_q, col_q);
                     data_q   <= word;
                     // Counters stay on the last pixel once the image is complete.
                     if (col_q == COL_LAST) begin
                        if (row_q == ROW_LAST) begin
                           state_q <= DONE;
                        end else begin
                           col_q <= '0;
                           row_q <= row_q + 11'd1;
                        end
                     end else begin
                        col_q <= col_q + 5'd1;
                     end
                  end else begin
                     ch_cnt_q <= ch_cnt_q + 2'd1;
                  end
               end
            end
            DONE: begin
               if (pix_beat) ovf_q <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign write_pixel_signal = strobe_q;
   assign write_pixel_addr   = addr_q;
   assign write_pixel_data   = data_q;
   assign pixel_store_done   = done_q;
   assign loader_busy        = (state_q == COLLECT);
   assign overflow           = ovf_q;
`ifdef CNN_LOADER_CKSUM_EN
   assign checksum           = cksum_q;
`endif

endmodule

// File: tb/tb_cnn_pixel_loader.sv
// Directed bench for cnn_pixel_loader with a 4x2 image; checksum steps run only when
// CNN_LOADER_CKSUM_EN is defined.
module tb_cnn_pixel_loader;

   localparam logic [31:0] PIX_A  = 32'hc000_0000;
   localparam logic [31:0] CTRL_A = 32'hc001_0000;
   localparam logic [31:0] OTHER  = 32'hb000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        write_pixel_signal;
   logic [15:0] write_pixel_addr;
   logic [47:0] write_pixel_data;
   logic        pixel_store_done;
   logic        loader_busy;
   logic        overflow;
`ifdef CNN_LOADER_CKSUM_EN
   logic [15:0] checksum;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cnn_pixel_loader_if bus ();

   cnn_pixel_loader #(
      .IMG_W (4),
      .IMG_H (2)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .bus                (bus),
      .write_pixel_signal (write_pixel_signal),
      .write_pixel_addr   (write_pixel_addr),
      .write_pixel_data   (write_pixel_data),
      .pixel_store_done   (pixel_store_done),
      .loader_busy        (loader_busy),
      .overflow           (overflow)
`ifdef CNN_LOADER_CKSUM_EN
      ,
      .checksum           (checksum)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One accepted beat; returns 1 time unit after the sampling edge.
   task automatic beat(input logic [31:0] a, input logic [31:0] d);
      bus.awaddr  = a;
      bus.wdata   = d;
      bus.awvalid = 1'b1;
      bus.wvalid  = 1'b1;
      @(posedge clk);
      #1;
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst         = 1'b0;
      bus.awaddr  = '0;
      bus.wdata   = '0;
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      idle(2);
      chk("rst_strobe", 64'(write_pixel_signal), 64'd0);
      chk("rst_addr",   64'(write_pixel_addr),   64'd0);
      chk("rst_data",   64'(write_pixel_data),   64'd0);
      chk("rst_done",   64'(pixel_store_done),   64'd0);
      chk("rst_busy",   64'(loader_busy),        64'd0);
      chk("rst_ovf",    64'(overflow),           64'd0);
      rst = 1'b1;
      idle(1);

      // Single pixel: strobe one cycle after the third beat.
      beat(PIX_A, 32'h0001);
      chk("p1_busy",    64'(loader_busy),        64'd1);
      chk("p1_strobe0", 64'(write_pixel_signal), 64'd0);
      beat(PIX_A, 32'h0002);
      chk("p1_strobe1", 64'(write_pixel_signal), 64'd0);
      beat(PIX_A, 32'h0003);
      chk("p1_strobe",  64'(write_pixel_signal), 64'd1);
      chk("p1_addr",    64'(write_pixel_addr),   64'h0000);
      chk("p1_data",    64'(write_pixel_data),   64'h0003_0002_0001);
      idle(1);
      chk("p1_strobe_off", 64'(write_pixel_signal), 64'd0);
      chk("p1_data_hold",  64'(write_pixel_data),   64'h0003_0002_0001);

      // Restart, then a beat with only awvalid must not be accepted.
      beat(CTRL_A, 32'h1);
      chk("rs_busy", 64'(loader_busy), 64'd0);
      bus.awaddr  = PIX_A;
      bus.awvalid = 1'b1;
      idle(1);
      bus.awvalid = 1'b0;
      chk("half_beat_busy", 64'(loader_busy), 64'd0);

      // Full image, back to back: 24 beats -> 8 strobes.
      for (int i = 0; i < 24; i++) begin
         beat(PIX_A, 32'(i + 1));
         if (i % 3 == 2) begin
            int k;
            logic [15:0] ea;
            logic [47:0] ed;
            k  = i / 3;
            ea = {11'(k / 4), 5'(k % 4)};
            ed = {16'(i + 1), 16'(i), 16'(i - 1)};
            chk($sformatf("img_strobe%0d", k), 64'(write_pixel_signal), 64'd1);
            chk($sformatf("img_addr%0d", k),   64'(write_pixel_addr),   64'(ea));
            chk($sformatf("img_data%0d", k),   64'(write_pixel_data),   64'(ed));
         end else begin
            chk($sformatf("img_nostrobe_b%0d", i), 64'(write_pixel_signal), 64'd0);
         end
         chk($sformatf("img_done_b%0d", i), 64'(pixel_store_done), 64'd0);
      end
      chk("img_busy_end", 64'(loader_busy), 64'd0);
      idle(1);
      chk("img_done",        64'(pixel_store_done),   64'd1);
      chk("img_strobe_after", 64'(write_pixel_signal), 64'd0);

      // Extra pixel beat after done.
      beat(PIX_A, 32'h0025);
      chk("ovf_strobe", 64'(write_pixel_signal), 64'd0);
      chk("ovf_flag",   64'(overflow),           64'd1);
      chk("ovf_done",   64'(pixel_store_done),   64'd1);
      chk("ovf_data",   64'(write_pixel_data),   64'h0018_0017_0016);

      // Asynchronous reset between clock edges.
      #3;
      rst = 1'b0;
      #1;
      chk("arst_done", 64'(pixel_store_done), 64'd0);
      chk("arst_ovf",  64'(overflow),         64'd0);
      chk("arst_addr", 64'(write_pixel_addr), 64'd0);
      chk("arst_data", 64'(write_pixel_data), 64'd0);
      idle(1);
      rst = 1'b1;
      idle(1);

      // Restart mid-pixel, ignored address, ctrl with wdata[0]=0.
      beat(PIX_A, 32'hAAAA);
      beat(PIX_A, 32'hBBBB);
      chk("mid_busy", 64'(loader_busy), 64'd1);
      beat(CTRL_A, 32'h1);
      chk("mid_rs_busy",   64'(loader_busy),        64'd0);
      chk("mid_rs_strobe", 64'(write_pixel_signal), 64'd0);
      beat(PIX_A, 32'h0011);
      beat(OTHER, 32'h0099);
      chk("mid_other", 64'(write_pixel_signal), 64'd0);
      beat(PIX_A, 32'h0022);
      beat(CTRL_A, 32'h0);
      chk("mid_ctrl0_busy",   64'(loader_busy),        64'd1);
      chk("mid_ctrl0_strobe", 64'(write_pixel_signal), 64'd0);
      beat(PIX_A, 32'h0033);
      chk("mid_strobe", 64'(write_pixel_signal), 64'd1);
      chk("mid_addr",   64'(write_pixel_addr),   64'h0000);
      chk("mid_data",   64'(write_pixel_data),   64'h0033_0022_0011);

`ifdef CNN_LOADER_CKSUM_EN
      beat(CTRL_A, 32'h1);
      chk("ck_clear", 64'(checksum), 64'd0);
      for (int i = 0; i < 24; i++) begin
         beat(PIX_A, 32'h1000);
      end
      chk("ck_sum", 64'(checksum), 64'h8000);
      beat(OTHER, 32'h1234);
      chk("ck_other", 64'(checksum), 64'h8000);
      beat(PIX_A, 32'h1234);
      chk("ck_done_beat", 64'(checksum),         64'h8000);
      chk("ck_done",      64'(pixel_store_done), 64'd1);
`endif

      idle(1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
